// File: rtl/lmsm_sequencer_if.sv
// lmsm_sequencer_if: pipe1-to-decode bus carried through the LM/SM sequencer
interface lmsm_sequencer_if;
    logic [15:0] IR;
    logic        valid_in;
    logic        stall_in;
    logic        flush;
    logic [15:0] IR_out;
    logic        valid_out;
    logic        uop_first;
    logic        uop_last;
    logic        stall_fetch;
    modport master (
        output IR, valid_in, stall_in, flush,
        input  IR_out, valid_out, uop_first, uop_last, stall_fetch
    );
    modport slave (
        input  IR, valid_in, stall_in, flush,
        output IR_out, valid_out, uop_first, uop_last, stall_fetch
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: expands LM/SM into one micro-op per listed register, passes other instructions through
module lmsm_sequencer (
    input logic               clk,
    input logic               reset,
    lmsm_sequencer_if.slave   bus
);
    localparam logic [3:0] OPC_LM = 4'b0110;
    localparam logic [3:0] OPC_SM = 4'b0111;
    typedef enum logic {IDLE, SEQ} state_t;
    state_t      state;
    logic [6:0]  held_hdr;
    logic [7:0]  mask;
    logic [2:0]  cnt;
    logic        is_lsm;
    logic [7:0]  list;
    logic [7:0]  rest;
    logic [6:0]  hdr;
    logic [2:0]  tgt;
    logic [2:0]  off;
    logic [15:0] uop;
    // Next micro-op: from pipe1 when idle, from the latched instruction while sequencing
    always_comb begin
        is_lsm = (bus.IR[15:12] == OPC_LM) || (bus.IR[15:12] == OPC_SM);
        list   = (state == SEQ) ? mask : bus.IR[7:0];
        hdr    = (state == SEQ) ? held_hdr : bus.IR[15:9];
        off    = (state == SEQ) ? cnt : 3'd0;
        rest   = list & (list - 8'd1);
        tgt    = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (list[i]) tgt = 3'(i);
        uop    = {hdr, tgt, off, 3'b000};
    end
    assign bus.stall_fetch = (state == SEQ) || bus.stall_in;
    // Sequencer FSM with registered outputs; reset beats flush, flush beats stall
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            held_hdr      <= '0;
            mask          <= '0;
            cnt           <= '0;
            bus.IR_out    <= '0;
            bus.valid_out <= 1'b0;
            bus.uop_first <= 1'b0;
            bus.uop_last  <= 1'b0;
        end else if (bus.flush) begin
            state         <= IDLE;
            mask          <= '0;
            cnt           <= '0;
            bus.valid_out <= 1'b0;
            bus.uop_first <= 1'b0;
            bus.uop_last  <= 1'b0;
        end else if (!bus.stall_in) begin
            case (state)
                IDLE: begin
                    if (!bus.valid_in || (is_lsm && list == 8'd0)) begin
                        bus.valid_out <= 1'b0;
                        bus.uop_first <= 1'b0;
                        bus.uop_last  <= 1'b0;
                    end else if (is_lsm) begin
                        bus.IR_out    <= uop;
                        bus.valid_out <= 1'b1;
                        bus.uop_first <= 1'b1;
                        bus.uop_last  <= (rest == 8'd0);
                        if (rest != 8'd0) begin
                            held_hdr <= bus.IR[15:9];
                            mask     <= rest;
                            cnt      <= 3'd1;
                            state    <= SEQ;
                        end
                    end else begin
                        bus.IR_out    <= bus.IR;
                        bus.valid_out <= 1'b1;
                        bus.uop_first <= 1'b0;
                        bus.uop_last  <= 1'b0;
                    end
                end
                SEQ: begin
                    bus.IR_out    <= uop;
                    bus.valid_out <= 1'b1;
                    bus.uop_first <= 1'b0;
                    bus.uop_last  <= (rest == 8'd0);
                    mask          <= rest;
                    cnt           <= (rest == 8'd0) ? 3'd0 : cnt + 3'd1;
                    if (rest == 8'd0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: directed checks of passthrough, LM/SM expansion, stall, flush and reset
module tb_lmsm_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    lmsm_sequencer_if bus();
    lmsm_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic expect_out(input string tag, input logic [15:0] ir, input logic v,
                              input logic f, input logic l, input logic sf);
        if (v) chk({tag, ".ir"}, bus.IR_out, ir);
        chk({tag, ".valid"}, 16'(bus.valid_out), 16'(v));
        chk({tag, ".first"}, 16'(bus.uop_first), 16'(f));
        chk({tag, ".last"}, 16'(bus.uop_last), 16'(l));
        chk({tag, ".stall_fetch"}, 16'(bus.stall_fetch), 16'(sf));
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.IR = 16'h0000; bus.valid_in = 1'b0; bus.stall_in = 1'b0; bus.flush = 1'b0;
        #1;
        step(); step();
        chk("rst.ir", bus.IR_out, 16'h0000);
        expect_out("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.stall_in = 1'b1; #1;
        chk("rst.sf_follows", 16'(bus.stall_fetch), 16'd1);
        bus.stall_in = 1'b0;
        reset = 1'b1;
        // passthrough
        bus.IR = 16'h0298; bus.valid_in = 1'b1; #1;
        chk("add.sf_pre", 16'(bus.stall_fetch), 16'd0);
        step(); expect_out("add", 16'h0298, 1'b1, 1'b0, 1'b0, 1'b0);
        // 4-op LM then ADD with no bubble
        bus.IR = 16'h64A5; step(); expect_out("lm.op1", 16'h6400, 1'b1, 1'b1, 1'b0, 1'b1);
        bus.IR = 16'h0298; step(); expect_out("lm.op2", 16'h6488, 1'b1, 1'b0, 1'b0, 1'b1);
        step(); expect_out("lm.op3", 16'h6550, 1'b1, 1'b0, 1'b0, 1'b1);
        step(); expect_out("lm.op4", 16'h65D8, 1'b1, 1'b0, 1'b1, 1'b0);
        step(); expect_out("lm.next", 16'h0298, 1'b1, 1'b0, 1'b0, 1'b0);
        // SM with empty list and with only R7
        bus.IR = 16'h7000; step(); expect_out("sm.empty", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.IR = 16'h7680; step(); expect_out("sm.r7", 16'h77C0, 1'b1, 1'b1, 1'b1, 1'b0);
        // stall_in for two cycles after op 2
        bus.IR = 16'h64A5; step(); expect_out("st.op1", 16'h6400, 1'b1, 1'b1, 1'b0, 1'b1);
        bus.IR = 16'h0298; step(); expect_out("st.op2", 16'h6488, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.stall_in = 1'b1;
        step(); expect_out("st.hold1", 16'h6488, 1'b1, 1'b0, 1'b0, 1'b1);
        step(); expect_out("st.hold2", 16'h6488, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.stall_in = 1'b0;
        step(); expect_out("st.op3", 16'h6550, 1'b1, 1'b0, 1'b0, 1'b1);
        step(); expect_out("st.op4", 16'h65D8, 1'b1, 1'b0, 1'b1, 1'b0);
        step(); expect_out("st.next", 16'h0298, 1'b1, 1'b0, 1'b0, 1'b0);
        // flush on the 2nd micro-op
        bus.IR = 16'h64A5; step(); expect_out("fl.op1", 16'h6400, 1'b1, 1'b1, 1'b0, 1'b1);
        step(); expect_out("fl.op2", 16'h6488, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.flush = 1'b1; bus.valid_in = 1'b0;
        step(); expect_out("fl.kill", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.flush = 1'b0;
        step(); expect_out("fl.idle", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        // flush together with stall_in: flush wins
        bus.IR = 16'h64A5; bus.valid_in = 1'b1;
        step(); expect_out("fs.op1", 16'h6400, 1'b1, 1'b1, 1'b0, 1'b1);
        step(); expect_out("fs.op2", 16'h6488, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.flush = 1'b1; bus.stall_in = 1'b1; bus.IR = 16'h0298;
        step(); expect_out("fs.kill", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.flush = 1'b0; bus.stall_in = 1'b0; #1;
        chk("fs.sf_idle", 16'(bus.stall_fetch), 16'd0);
        step(); expect_out("fs.next", 16'h0298, 1'b1, 1'b0, 1'b0, 1'b0);
        // reset mid-sequence, then a fresh LM starts at offset 0
        bus.IR = 16'h64A5; step(); expect_out("rs.op1", 16'h6400, 1'b1, 1'b1, 1'b0, 1'b1);
        step(); expect_out("rs.op2", 16'h6488, 1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        step();
        chk("rs.ir", bus.IR_out, 16'h0000);
        expect_out("rs.rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step(); expect_out("rs.new1", 16'h6400, 1'b1, 1'b1, 1'b0, 1'b1);
        bus.valid_in = 1'b0;
        step(); expect_out("rs.new2", 16'h6488, 1'b1, 1'b0, 1'b0, 1'b1);
        step(); expect_out("rs.new3", 16'h6550, 1'b1, 1'b0, 1'b0, 1'b1);
        step(); expect_out("rs.new4", 16'h65D8, 1'b1, 1'b0, 1'b1, 1'b0);
        step(); expect_out("rs.drain", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
